// File: rtl/median_to_bram_writer_controller_pkg.sv
// ---------------------------------------------------------------------------
// median_pkg
// Shared definitions for the median filter datapath: the writer FSM state
// encoding, default image geometry shared with the read controller and the
// median core, and a width helper that never returns zero.
// ---------------------------------------------------------------------------
package median_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_IMG_W  = 64;
    localparam int DEF_IMG_H  = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wr_state_e;

    // Counter width for a range of n values; a 1-deep dimension still gets a
    // 1-bit port so the vectors stay legal.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/median_to_bram_writer_controller_if.sv
// ---------------------------------------------------------------------------
// median_to_bram_writer_controller_if
// Bundles the median-result input, the output BRAM write port and the
// status outputs of the writer controller.
//   slave  : the controller (consumes start/valid/data, drives BRAM + status)
//   master : the producer/observer side (drives start/valid/data)
// ---------------------------------------------------------------------------
interface median_to_bram_writer_controller_if
    import median_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = $clog2(IMG_W * IMG_H)
);
    localparam int ROW_W = cnt_w(IMG_H);
    localparam int COL_W = cnt_w(IMG_W);

    logic              i_start;
    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic              o_bram_we;
    logic [ADDR_W-1:0] o_bram_addr;
    logic [DATA_W-1:0] o_bram_wdata;
    logic [ROW_W-1:0]  o_row;
    logic [COL_W-1:0]  o_col;
    logic              o_done;
    logic              o_err;
    logic [1:0]        o_state;

    modport slave (
        input  i_start, i_valid, i_data,
        output o_bram_we, o_bram_addr, o_bram_wdata,
        output o_row, o_col, o_done, o_err, o_state
    );

    modport master (
        output i_start, i_valid, i_data,
        input  o_bram_we, o_bram_addr, o_bram_wdata,
        input  o_row, o_col, o_done, o_err, o_state
    );

endinterface

// File: rtl/median_wr_addr_gen.sv
// ---------------------------------------------------------------------------
// median_wr_addr_gen
// Raster-order write position: linear address plus row/column counters.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clear      : force all counters to 0 (start of frame)
//   i_advance    : step to the next pixel; wraps to 0 after the last one
//   o_addr/o_row/o_col : position of the next pixel to be written
//   o_last       : current position is the final pixel of the frame
// ---------------------------------------------------------------------------
module median_wr_addr_gen
    import median_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = $clog2(IMG_W * IMG_H),
    parameter int ROW_W  = cnt_w(IMG_H),
    parameter int COL_W  = cnt_w(IMG_W)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_addr,
    output logic [ROW_W-1:0]  o_row,
    output logic [COL_W-1:0]  o_col,
    output logic              o_last
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;

    assign o_last = (addr_q == LAST_ADDR);

    always_comb begin
        addr_d = addr_q;
        row_d  = row_q;
        col_d  = col_q;
        if (i_clear || (i_advance && o_last)) begin
            // Explicit wrap: the address never relies on natural overflow,
            // which matters when IMG_W*IMG_H is not a power of two.
            addr_d = '0;
            row_d  = '0;
            col_d  = '0;
        end else if (i_advance) begin
            addr_d = addr_q + 1'b1;
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
        end else begin
            addr_q <= addr_d;
            row_q  <= row_d;
            col_q  <= col_d;
        end
    end

    assign o_addr = addr_q;
    assign o_row  = row_q;
    assign o_col  = col_q;

endmodule

// File: rtl/median_to_bram_writer_controller.sv
// ---------------------------------------------------------------------------
// median_to_bram_writer_controller
// Captures one median result per i_valid pulse and writes it, in raster
// order, into the output BRAM; flags frame completion and dropped results.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : i_start/i_valid/i_data in; BRAM write port
//                  (o_bram_we/addr/wdata), o_row/o_col (next pixel),
//                  o_done (level), o_err (sticky drop flag), o_state
// ---------------------------------------------------------------------------
module median_to_bram_writer_controller
    import median_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic i_clk,
    input  logic i_rst,
    median_to_bram_writer_controller_if.slave bus
);
    localparam int ROW_W = cnt_w(IMG_H);
    localparam int COL_W = cnt_w(IMG_W);

    wr_state_e         state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;

    logic              clear, accept, drop;
    logic [ADDR_W-1:0] cnt_addr;
    logic [ROW_W-1:0]  cnt_row;
    logic [COL_W-1:0]  cnt_col;
    logic              cnt_last;

    median_wr_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W)
    ) u_addr_gen (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (clear),
        .i_advance (accept),
        .o_addr    (cnt_addr),
        .o_row     (cnt_row),
        .o_col     (cnt_col),
        .o_last    (cnt_last)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; start is deliberately ignored while writing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.i_start) state_d = WRITE;
            WRITE:   if (bus.i_valid && cnt_last) state_d = DONE;
            DONE:    if (bus.i_start) state_d = WRITE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath control
    always_comb begin
        clear   = ((state_q == IDLE) || (state_q == DONE)) && bus.i_start;
        accept  = (state_q == WRITE) && bus.i_valid;
        drop    = (state_q != WRITE) && bus.i_valid;
        we_d    = accept;
        wdata_d = accept ? bus.i_data : wdata_q;
        waddr_d = accept ? cnt_addr : waddr_q;
        // A start clears the flag, but a result arriving with that same
        // start is still dropped and must be reported.
        err_d   = clear ? drop : (err_q | drop);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // The counters have already moved on by the time we is high, so the
    // BRAM address comes from the registered copy during a write.
    assign bus.o_bram_we    = we_q;
    assign bus.o_bram_addr  = we_q ? waddr_q : cnt_addr;
    assign bus.o_bram_wdata = wdata_q;
    assign bus.o_row        = cnt_row;
    assign bus.o_col        = cnt_col;
    assign bus.o_done       = (state_q == DONE);
    assign bus.o_err        = err_q;
    assign bus.o_state      = state_q;

endmodule

// File: doc/median_to_bram_writer_controller.md
Name: median_to_bram_writer_controller

Overview:
- Write-side counterpart of the BRAM-to-median read controller.
- Captures each median result pulse from the 9x9 median stage and writes it, in raster order, into the output BRAM.
- Generates the write enable, linear address and row/column position, and reports frame completion and dropped results.
- Sits between the median calculator and the MRELBP feature stage, which reads the filtered image from the output BRAM.

Parameters:
- DATA_W, 8, width of one median pixel.
- IMG_W, 64, output image width in pixels.
- IMG_H, 64, output image height in pixels.
- ADDR_W, $clog2(IMG_W*IMG_H), output BRAM address width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_start  in  1  one-cycle pulse that begins a new frame.
- i_valid  in  1  median result valid, one-cycle pulse per pixel.
- i_data  in  DATA_W  median result, sampled when i_valid=1.
- o_bram_we  out  1  output BRAM write enable.
- o_bram_addr  out  ADDR_W  output BRAM write address.
- o_bram_wdata  out  DATA_W  output BRAM write data.
- o_row  out  $clog2(IMG_H)  row of the next pixel to be written.
- o_col  out  $clog2(IMG_W)  column of the next pixel to be written.
- o_done  out  1  frame complete (level).
- o_err  out  1  sticky flag: a result arrived outside WRITE and was dropped.
- o_state  out  2  current FSM state, for test.

Behaviour:
- Reset (asynchronous, active-high), all outputs return to 0:
  - state=IDLE.
  - o_bram_we, o_bram_addr, o_bram_wdata, o_row, o_col, o_done and o_err all 0.
- FSM states: IDLE=0, WRITE=1, DONE=2. Encoding 3 is illegal and recovers to IDLE on the next clock.
- IDLE: i_start -> WRITE. Address, row and col are cleared to 0 and o_err is cleared.
- WRITE handling of i_valid:
  - i_valid=1 registers o_bram_we=1, o_bram_wdata=i_data and o_bram_addr=current address on the next edge. Latency from i_valid to we is 1 cycle.
  - o_bram_we is high for exactly one cycle per accepted result.
  - Back-to-back i_valid (every cycle) is accepted with no gaps.
- WRITE address advance:
  - After each accepted result, address increments by 1.
  - col increments; when col wraps from IMG_W-1 to 0, row increments.
- WRITE end of frame:
  - The accepted result at address IMG_W*IMG_H-1 (row=IMG_H-1, col=IMG_W-1) is written, and the state moves to DONE in the same edge.
  - Address, row and col then wrap to 0.
- DONE:
  - o_done=1 while in DONE.
  - i_start -> WRITE, with the same clearing as from IDLE; o_done drops on that edge.
- i_valid in IDLE or DONE: the result is dropped, o_bram_we stays 0, and o_err is set. o_err holds until reset or the next accepted i_start.
- i_start while in WRITE: ignored. The frame continues and no counters are cleared.
- i_start and i_valid in the same cycle in IDLE/DONE: the start is taken, the valid is dropped, and o_err is set. o_err is cleared on the following start only.
- Reset mid-frame: the frame is abandoned. Nothing is written after reset is asserted, and pixels already written are not rewritten.
- o_row, o_col and o_bram_addr are the unregistered counter values when we=0. While we=1, o_bram_addr holds the registered address of the current write.
- The address counter never exceeds IMG_W*IMG_H-1; the wrap to 0 is explicit, not natural overflow.

Decomposition:
- Shared package median_pkg:
  - writer state enum wr_state_e {IDLE, WRITE, DONE}, 2-bit.
  - default IMG_W/IMG_H/DATA_W constants, shared with the read controller and the median core.
- One sub-module, median_wr_addr_gen:
  - linear address plus row/col counters.
  - inputs: clear, advance.
  - output: last flag, high when address = IMG_W*IMG_H-1.
- The FSM, output registers and error flag stay in the top module.

Test Plan (IMG_W=4, IMG_H=2, DATA_W=8):
- Reset check: assert i_rst mid-cycle -> all outputs 0 asynchronously, o_state=0. Deassert, then idle 10 cycles -> no writes.
- Full frame, spaced inputs: i_start, then 8 i_valid pulses every 81 cycles with data 0x10..0x17 -> 8 single-cycle writes to addr 0..7 with the matching data. Row/col go (0,0)..(1,3). After the 8th write: o_done=1, o_state=2.
- Full frame, back-to-back: i_start, then i_valid held high 8 cycles with data 0xA0..0xA7 -> we high 8 consecutive cycles, addr 0..7, then o_done=1. A 9th valid in DONE -> no write, o_err=1.
- Restart: from DONE with o_err=1, pulse i_start -> o_done=0, o_err=0, addr=0. The next valid with data 0x55 writes addr 0.
- Ignored start: after 3 writes, pulse i_start -> next write goes to addr 3, not 0.
- Abandoned frame: assert reset after 5 writes -> state IDLE, addr 0. A following i_start plus one valid with data 0x33 writes addr 0.
